axis_packet_fifo: RTL and testbench
===================================

# axis_packet_fifo

Parametrised AXI-Stream FIFO buffering tdata/tkeep/tlast beats between an upstream master and a downstream slave in the LDPC datapath. It generalises the plain AXI-Stream handshake with configurable width and depth, occupancy and packet-count status, and an optional store-and-forward packet mode. In packet mode, output is held until a complete packet (tlast) is stored. Used to decouple encoder/decoder stages and to absorb codeword-length bursts.

## Interface
- DATA_WIDTH, 64: tdata width in bits; multiple of 8; tkeep is DATA_WIDTH/8.
- DEPTH, 16: storage depth in beats; power of two, ≥ 2.
- PACKET_MODE, 0: 0 = cut-through; 1 = store-and-forward.
- CW = $clog2(DEPTH+1): width of status counters (derived, not overridable).

Ports:
- aclk  in  1  clock; all state on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_tvalid  in  1  upstream beat valid.
- s_tready  out  1  FIFO can accept a beat.
- s_tdata  in  DATA_WIDTH  upstream data.
- s_tkeep  in  DATA_WIDTH/8  upstream byte enables; stored verbatim.
- s_tlast  in  1  upstream end of packet.
- m_tvalid  out  1  downstream beat valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  DATA_WIDTH  head-of-FIFO data.
- m_tkeep  out  DATA_WIDTH/8  head-of-FIFO byte enables.
- m_tlast  out  1  head-of-FIFO end of packet.
- level  out  CW  beats currently stored, 0..DEPTH.
- pkt_count  out  CW  complete packets stored (tlast beats in FIFO), 0..DEPTH.

## Operation
- Write: beat accepted when s_tvalid & s_tready. Read: beat retired when m_tvalid & m_tready.
- Storage is a circular buffer with log2(DEPTH)+1-bit read/write pointers; pointers wrap at DEPTH. Full = MSBs differ and LSBs equal.
- s_tready = (level != DEPTH), registered. No combinational path from m_tready to s_tready. When full, a same-cycle read does not permit a same-cycle write.
- level: +1 on write only, −1 on read only, unchanged on both or neither.
- pkt_count: +1 on a write with s_tlast, −1 on a read with m_tlast, unchanged when both occur.
- PACKET_MODE=0: m_tvalid = (level != 0).
- PACKET_MODE=1: m_tvalid = (level != 0) & ((pkt_count != 0) | release).
- Release flag (packet mode only) prevents deadlock on packets longer than DEPTH:
  - Set when level == DEPTH and pkt_count == 0.
  - Cleared on a read beat with m_tlast.
  - While set, the FIFO behaves as cut-through until that packet's tlast exits.
- m_tdata/m_tkeep/m_tlast show the head entry whenever m_tvalid = 1. They hold stable while m_tvalid & !m_tready.
- Input protocol violations (s_tdata changing under s_tvalid & !s_tready) are not checked.

## Timing
- Reset (areset high, async): pointers, level, pkt_count and release cleared. m_tvalid = 0, s_tready = 0, m_tlast = 0. m_tdata/m_tkeep are don't-care. Storage RAM is not cleared.
- s_tready rises at the first aclk edge after areset deasserts.
- Reset mid-packet discards all stored beats; no partial packet survives.
- Cut-through latency: beat written at edge N is visible with m_tvalid = 1 after edge N (cycle N+1).
- Packet-mode latency: first beat visible in the cycle after the edge that writes the tlast beat.
- Throughput: one beat per cycle sustained in both directions when neither full nor empty.
- level and pkt_count are registered and update on the same edge as the transfer.

## Test plan
- Reset and idle, PACKET_MODE=0, DEPTH=16:
  - Assert areset mid-cycle → m_tvalid = 0, s_tready = 0, level = 0 immediately.
  - Deassert areset → s_tready = 1 after the next edge.
- Fill and drain, DEPTH=16, m_tready=0:
  - Write 16 beats 0x00..0x0F → s_tready = 0 and level = 16 after the 16th write.
  - Raise m_tready → beats 0x00..0x0F out in order, tkeep preserved; level returns to 0.
- Simultaneous read/write:
  - At level = 5 with continuous valid/ready for 100 cycles → level stays 5; output sequence equals input sequence delayed by 5 beats.
  - At level = 16 with m_tready=1 and s_tvalid=1 → exactly one read and no write that cycle; level = 15.
- Packet mode, PACKET_MODE=1:
  - Write a 4-beat packet with tlast on beat 4 → m_tvalid stays 0 through beats 1–3 and rises the cycle after beat 4; pkt_count = 1.
  - Drain it → pkt_count = 0.
- Oversize packet, PACKET_MODE=1, DEPTH=8:
  - Write a 20-beat packet with m_tready=1 → release sets at level = 8, beats stream out cut-through, release clears after beat 20 exits.
  - All 20 beats arrive intact with no deadlock.
- Random backpressure:
  - 1000 random packets, lengths 1–12, random tkeep, 30% random valid/ready stalls → scoreboard matches data/keep/last exactly.
  - level never exceeds DEPTH; pkt_count always equals the count of tlast beats resident in the FIFO.

Source files
------------

// File: rtl/axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_packet_fifo
// Description : AXI-Stream FIFO for tdata/tkeep/tlast beats with occupancy
//               and packet-count status. Optional store-and-forward mode
//               holds output until a complete packet is resident, with a
//               release escape for packets longer than the storage depth.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_fifo #(
    parameter int  DATA_WIDTH  = 64,
    parameter int  DEPTH       = 16,
    parameter int  PACKET_MODE = 0,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                      aclk,
    input  logic                      areset,
    // upstream slave port
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                      s_tlast,
    // downstream master port
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    // status
    output logic [CW-1:0]             level,
    output logic [CW-1:0]             pkt_count
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Storage (not reset; contents are qualified by the pointers)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [KW-1:0]         keep_mem [DEPTH];
    logic [DEPTH-1:0]      last_mem;

    // Pointers carry one extra wrap bit so full and empty are distinct
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_nxt;
    logic [AW:0]   rd_ptr_nxt;
    logic          full_nxt;

    logic          wr_en;
    logic          rd_en;
    logic          head_last;
    logic          out_valid;
    logic          ready_q;

    logic [CW-1:0] level_q;
    logic [CW-1:0] level_nxt;
    logic [CW-1:0] pkt_q;
    logic [CW-1:0] pkt_nxt;

    assign wr_en     = s_tvalid & ready_q;
    assign rd_en     = out_valid & m_tready;
    assign head_last = last_mem[rd_ptr[AW-1:0]];

    // Write the accepted beat into the slot addressed by the write pointer
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            data_mem[wr_ptr[AW-1:0]] <= s_tdata;
            keep_mem[wr_ptr[AW-1:0]] <= s_tkeep;
            last_mem[wr_ptr[AW-1:0]] <= s_tlast;
        end
    end

    // Next pointer values and the full condition they will produce
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (wr_en) begin
            wr_ptr_nxt = wr_ptr + (AW+1)'(1);
        end
        if (rd_en) begin
            rd_ptr_nxt = rd_ptr + (AW+1)'(1);
        end
        full_nxt = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                   (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end

    // Pointer registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Registered ready derived from next-state fullness only, so m_tready
    // never reaches s_tready combinationally; a read while full does not
    // open a write slot in that same cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ~full_nxt;
        end
    end

    // Occupancy and resident-packet counters: next-state arithmetic
    always_comb begin
        level_nxt = level_q;
        pkt_nxt   = pkt_q;
        case ({wr_en, rd_en})
            2'b10:   level_nxt = level_q + CW'(1);
            2'b01:   level_nxt = level_q - CW'(1);
            default: level_nxt = level_q;
        endcase
        case ({wr_en & s_tlast, rd_en & head_last})
            2'b10:   pkt_nxt = pkt_q + CW'(1);
            2'b01:   pkt_nxt = pkt_q - CW'(1);
            default: pkt_nxt = pkt_q;
        endcase
    end

    // Occupancy and resident-packet counter registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            level_q <= '0;
            pkt_q   <= '0;
        end else begin
            level_q <= level_nxt;
            pkt_q   <= pkt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output qualification
    // ------------------------------------------------------------------
    generate
        if (PACKET_MODE != 0) begin : g_store_forward
            logic release_q;

            // A full FIFO holding no tlast can never complete a packet, so
            // fall back to cut-through until that packet's tlast leaves.
            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    release_q <= 1'b0;
                end else if ((level_q == FULL_LEVEL) && (pkt_q == '0)) begin
                    release_q <= 1'b1;
                end else if (rd_en && head_last) begin
                    release_q <= 1'b0;
                end
            end

            assign out_valid = (level_q != '0) && ((pkt_q != '0) || release_q);
        end else begin : g_cut_through
            assign out_valid = (level_q != '0);
        end
    endgenerate

    assign s_tready  = ready_q;
    assign m_tvalid  = out_valid;
    assign m_tdata   = data_mem[rd_ptr[AW-1:0]];
    assign m_tkeep   = keep_mem[rd_ptr[AW-1:0]];
    assign m_tlast   = out_valid & head_last;
    assign level     = level_q;
    assign pkt_count = pkt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_packet_fifo
// Description : Self-checking bench for axis_packet_fifo. Instance 0 is
//               cut-through with 16 entries, instance 1 is store-and-forward
//               with 8 entries. A queue-level model predicts every output on
//               each falling edge; directed phases add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packet_fifo;

    localparam int NI = 2;

    logic clk    = 1'b0;
    logic areset = 1'b1;

    // stimulus
    logic        s_tvalid [NI];
    logic [63:0] s_tdata  [NI];
    logic [7:0]  s_tkeep  [NI];
    logic        s_tlast  [NI];
    logic        m_tready [NI];

    // DUT outputs
    logic        s_tready0, s_tready1, m_tvalid0, m_tvalid1, m_tlast0, m_tlast1;
    logic [63:0] m_tdata0, m_tdata1;
    logic [7:0]  m_tkeep0, m_tkeep1;
    logic [4:0]  level0, pkt0;
    logic [3:0]  level1, pkt1;

    logic        s_tready_a [NI];
    logic        m_tvalid_a [NI];
    logic        m_tlast_a  [NI];
    logic [63:0] m_tdata_a  [NI];
    logic [7:0]  m_tkeep_a  [NI];
    logic [4:0]  level_a    [NI];
    logic [4:0]  pkt_a      [NI];

    int n_pass  = 0;
    int n_total = 0;

    axis_packet_fifo #(.DATA_WIDTH(64), .DEPTH(16), .PACKET_MODE(0)) dut0 (
        .aclk(clk), .areset(areset),
        .s_tvalid(s_tvalid[0]), .s_tready(s_tready0), .s_tdata(s_tdata[0]),
        .s_tkeep(s_tkeep[0]), .s_tlast(s_tlast[0]),
        .m_tvalid(m_tvalid0), .m_tready(m_tready[0]), .m_tdata(m_tdata0),
        .m_tkeep(m_tkeep0), .m_tlast(m_tlast0),
        .level(level0), .pkt_count(pkt0)
    );

    axis_packet_fifo #(.DATA_WIDTH(64), .DEPTH(8), .PACKET_MODE(1)) dut1 (
        .aclk(clk), .areset(areset),
        .s_tvalid(s_tvalid[1]), .s_tready(s_tready1), .s_tdata(s_tdata[1]),
        .s_tkeep(s_tkeep[1]), .s_tlast(s_tlast[1]),
        .m_tvalid(m_tvalid1), .m_tready(m_tready[1]), .m_tdata(m_tdata1),
        .m_tkeep(m_tkeep1), .m_tlast(m_tlast1),
        .level(level1), .pkt_count(pkt1)
    );

    always_comb begin
        s_tready_a[0] = s_tready0;  s_tready_a[1] = s_tready1;
        m_tvalid_a[0] = m_tvalid0;  m_tvalid_a[1] = m_tvalid1;
        m_tlast_a[0]  = m_tlast0;   m_tlast_a[1]  = m_tlast1;
        m_tdata_a[0]  = m_tdata0;   m_tdata_a[1]  = m_tdata1;
        m_tkeep_a[0]  = m_tkeep0;   m_tkeep_a[1]  = m_tkeep1;
        level_a[0]    = level0;     level_a[1]    = {1'b0, level1};
        pkt_a[0]      = pkt0;       pkt_a[1]      = {1'b0, pkt1};
    end

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: an ordered list of resident beats per instance
    // ------------------------------------------------------------------
    logic [72:0] mq [NI][16];       // {data, keep, last}
    int          mn [NI] = '{0, 0};
    bit          rel   [NI];
    bit          e_rdy [NI];
    bit          acc   [NI];
    int          pops  [NI] = '{0, 0};
    bit          src_done [NI];

    function automatic int depth_of(input int i);
        return (i == 0) ? 16 : 8;
    endfunction

    function automatic bit pm_of(input int i);
        return (i == 1);
    endfunction

    function automatic int tl_count(input int i);
        int c = 0;
        for (int k = 0; k < mn[i]; k++) if (mq[i][k][0]) c++;
        return c;
    endfunction

    function automatic bit e_val(input int i);
        return (mn[i] > 0) && (!pm_of(i) || (tl_count(i) > 0) || rel[i]);
    endfunction

    function automatic logic [7:0] kp(input int k);
        return 8'(k * 37 + 1);
    endfunction

    task automatic check(input string nm, input int i, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    endtask

    task automatic model_step();
        bit wr, rd, rs;
        if (areset) begin
            for (int i = 0; i < NI; i++) begin
                mn[i] = 0; rel[i] = 0; e_rdy[i] = 0; acc[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                wr = s_tvalid[i] && e_rdy[i];
                rd = e_val(i) && m_tready[i];
                rs = pm_of(i) && (mn[i] == depth_of(i)) && (tl_count(i) == 0);
                if (rd) begin
                    if (mq[i][0][0]) rel[i] = 0;
                    for (int k = 0; k < mn[i] - 1; k++) mq[i][k] = mq[i][k+1];
                    mn[i]--;
                    pops[i]++;
                end
                if (wr) begin
                    mq[i][mn[i]] = {s_tdata[i], s_tkeep[i], s_tlast[i]};
                    mn[i]++;
                end
                if (rs) rel[i] = 1;
                e_rdy[i] = (mn[i] != depth_of(i));
                acc[i]   = wr;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge areset);
        model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("s_tready", i, s_tready_a[i], e_rdy[i]);
            check("m_tvalid", i, m_tvalid_a[i], e_val(i));
            check("level", i, level_a[i], mn[i]);
            check("pkt_count", i, pkt_a[i], tl_count(i));
            if (e_val(i)) begin
                check("m_tdata", i, m_tdata_a[i], mq[i][0][72:9]);
                check("m_tkeep", i, m_tkeep_a[i], mq[i][0][8:1]);
                check("m_tlast", i, m_tlast_a[i], mq[i][0][0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_beat(input int i, input logic [63:0] d, input logic [7:0] k,
                             input logic l);
        int t = 0;
        s_tvalid[i] = 1'b1; s_tdata[i] = d; s_tkeep[i] = k; s_tlast[i] = l;
        do begin
            @(posedge clk); #1; t++;
        end while (!acc[i] && t < 400);
        check("send_accept", i, acc[i], 1);
    endtask

    task automatic wait_empty(input int i);
        int t = 0;
        while (mn[i] != 0 && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        check("drain_level", i, level_a[i], 0);
    endtask

    task automatic rand_src(input int i, input int npk);
        int len;
        for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 99) < 30) begin
                    s_tvalid[i] = 1'b0;
                    @(posedge clk); #1;
                end
                send_beat(i, {$urandom, $urandom}, 8'($urandom), b == len - 1);
            end
        end
        s_tvalid[i] = 1'b0;
        src_done[i] = 1'b1;
    endtask

    task automatic rand_sink(input int i);
        int t = 0;
        while ((!src_done[i] || mn[i] != 0) && t < 60000) begin
            m_tready[i] = ($urandom_range(0, 99) >= 30);
            @(posedge clk); #1; t++;
        end
        m_tready[i] = 1'b0;
        check("rand_drain", i, level_a[i], 0);
    endtask

    // ------------------------------------------------------------------
    // Directed and random phases
    // ------------------------------------------------------------------
    initial begin
        int maxl;
        int p0;
        for (int i = 0; i < NI; i++) begin
            s_tvalid[i] = 0; s_tdata[i] = '0; s_tkeep[i] = '0; s_tlast[i] = 0;
            m_tready[i] = 0; src_done[i] = 0;
        end

        // reset release: ready only after the first edge out of reset
        repeat (3) @(posedge clk);
        @(negedge clk); #2; areset = 1'b0;
        #1 check("ready_before_edge", 0, s_tready_a[0], 0);
        @(posedge clk); #1 check("ready_after_edge", 0, s_tready_a[0], 1);

        // mid-cycle reset discards a partial packet
        for (int k = 0; k < 3; k++) send_beat(0, 64'(k), 8'hFF, 1'b0);
        s_tvalid[0] = 1'b0;
        check("level_before_rst", 0, level_a[0], 3);
        @(posedge clk); #2 areset = 1'b1;
        #1;
        check("rst_m_tvalid", 0, m_tvalid_a[0], 0);
        check("rst_s_tready", 0, s_tready_a[0], 0);
        check("rst_level", 0, level_a[0], 0);
        @(negedge clk); #2 areset = 1'b0;
        @(posedge clk); #1 check("ready_after_rst", 0, s_tready_a[0], 1);

        // fill 16 beats with output stalled
        m_tready[0] = 1'b0;
        for (int k = 0; k < 16; k++) send_beat(0, 64'(k), kp(k), 1'b0);
        s_tvalid[0] = 1'b0;
        check("full_level", 0, level_a[0], 16);
        check("full_ready", 0, s_tready_a[0], 0);

        // full with both sides active: one read, no write
        s_tvalid[0] = 1'b1; s_tdata[0] = 64'hAA; s_tkeep[0] = 8'h0F; s_tlast[0] = 1'b0;
        m_tready[0] = 1'b1;
        check("head0_data", 0, m_tdata_a[0], 0);
        check("head0_keep", 0, m_tkeep_a[0], kp(0));
        @(posedge clk); #1;
        s_tvalid[0] = 1'b0;
        check("full_rw_level", 0, level_a[0], 15);
        check("full_rw_ready", 0, s_tready_a[0], 1);
        for (int k = 1; k < 16; k++) begin
            check("drain_data", 0, m_tdata_a[0], 64'(k));
            check("drain_keep", 0, m_tkeep_a[0], kp(k));
            @(posedge clk); #1;
        end
        check("drained_level", 0, level_a[0], 0);
        check("drained_valid", 0, m_tvalid_a[0], 0);
        m_tready[0] = 1'b0;

        // steady state at level 5 for 100 cycles
        for (int k = 0; k < 5; k++) send_beat(0, 64'(100 + k), kp(k), 1'b0);
        s_tdata[0] = 64'd105; s_tkeep[0] = kp(5);
        m_tready[0] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            check("steady_level", 0, level_a[0], 5);
            check("steady_data", 0, m_tdata_a[0], 64'(100 + k));
            @(posedge clk); #1;
            s_tdata[0] = 64'(106 + k); s_tkeep[0] = kp(6 + k);
        end
        s_tvalid[0] = 1'b0;
        wait_empty(0);
        m_tready[0] = 1'b0;

        // store-and-forward: 4-beat packet
        for (int b = 0; b < 4; b++) begin
            send_beat(1, 64'(200 + b), 8'hFF, b == 3);
            if (b < 3) check("pkt_hold_valid", 1, m_tvalid_a[1], 0);
        end
        s_tvalid[1] = 1'b0;
        check("pkt_ready_valid", 1, m_tvalid_a[1], 1);
        check("pkt_count_one", 1, pkt_a[1], 1);
        m_tready[1] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            check("pkt_out_data", 1, m_tdata_a[1], 64'(200 + b));
            check("pkt_out_last", 1, m_tlast_a[1], b == 3);
            @(posedge clk); #1;
        end
        check("pkt_count_zero", 1, pkt_a[1], 0);
        check("pkt_level_zero", 1, level_a[1], 0);

        // oversize 20-beat packet through an 8-deep store-and-forward FIFO
        maxl = 0;
        p0 = pops[1];
        for (int b = 0; b < 20; b++) begin
            send_beat(1, 64'(300 + b), 8'hF0, b == 19);
            if (int'(level_a[1]) > maxl) maxl = int'(level_a[1]);
            if (b == 0) check("big_hold_valid", 1, m_tvalid_a[1], 0);
        end
        s_tvalid[1] = 1'b0;
        wait_empty(1);
        check("big_beats_out", 1, pops[1] - p0, 20);
        check("big_max_level", 1, maxl, 8);
        check("big_idle_valid", 1, m_tvalid_a[1], 0);
        // release must be clear again: a lone non-last beat is held
        send_beat(1, 64'h55, 8'hFF, 1'b0);
        s_tvalid[1] = 1'b0;
        repeat (3) begin
            check("release_cleared", 1, m_tvalid_a[1], 0);
            @(posedge clk); #1;
        end
        send_beat(1, 64'h56, 8'hFF, 1'b1);
        s_tvalid[1] = 1'b0;
        wait_empty(1);
        m_tready[1] = 1'b0;

        // random packets with backpressure on both instances
        fork
            rand_src(0, 1000);
            rand_sink(0);
            rand_src(1, 1000);
            rand_sink(1);
        join

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
